// File: rtl/rans_dec_pkg.sv
// Shared constants and FSM state encoding for the rANS decoder.
package rans_pkg;

    localparam int RESOLUTION   = 10;
    localparam int SYMBOL_WIDTH = 8;
    localparam int STATE_WIDTH  = RESOLUTION + SYMBOL_WIDTH;
    localparam int L_MIN        = 1 << RESOLUTION;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOOKUP,
        CALC,
        RENORM,
        OUT
    } state_e;

endpackage

// File: rtl/rans_dec_if.sv
// Byte-stream input and decoded-symbol output handshakes of the rANS decoder.
interface rans_dec_if #(
    parameter int SYMBOL_WIDTH = rans_pkg::SYMBOL_WIDTH
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [SYMBOL_WIDTH-1:0] in_byte;
    logic                    sym_valid;
    logic                    sym_ready;
    logic [SYMBOL_WIDTH-1:0] sym;

    modport master (
        output in_valid, in_byte, sym_ready,
        input  in_ready, sym_valid, sym
    );

    modport slave (
        input  in_valid, in_byte, sym_ready,
        output in_ready, sym_valid, sym
    );

endinterface

// File: rtl/rans_dec_tables.sv
// Frequency/cumulative table (per symbol) and slot-to-symbol table, both with
// registered reads. The symbol read from the slot table addresses the freq table
// in the same cycle, so one lookup cycle yields symbol, freq and cum together.
module rans_dec_tables #(
    parameter int RESOLUTION   = rans_pkg::RESOLUTION,
    parameter int SYMBOL_WIDTH = rans_pkg::SYMBOL_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    freq_wr_i,
    input  logic                    slot_wr_i,
    input  logic [RESOLUTION-1:0]   freq_i,
    input  logic [RESOLUTION-1:0]   cum_freq_i,
    input  logic [RESOLUTION-1:0]   slot_i,
    input  logic [SYMBOL_WIDTH-1:0] symb_i,
    input  logic [RESOLUTION-1:0]   rd_slot_i,
    output logic [SYMBOL_WIDTH-1:0] rd_symb_o,
    output logic [RESOLUTION-1:0]   rd_freq_o,
    output logic [RESOLUTION-1:0]   rd_cum_o
);

    logic [2*RESOLUTION-1:0] freq_ram [2**SYMBOL_WIDTH];
    logic [SYMBOL_WIDTH-1:0] slot_ram [2**RESOLUTION];

    always_ff @(posedge clk_i) begin
        if (freq_wr_i) freq_ram[symb_i] <= {freq_i, cum_freq_i};
        if (slot_wr_i) slot_ram[slot_i] <= symb_i;
        rd_symb_o              <= slot_ram[rd_slot_i];
        {rd_freq_o, rd_cum_o}  <= freq_ram[slot_ram[rd_slot_i]];
    end

endmodule

// File: rtl/rans_dec.sv
// rANS stream decoder: loads a 3-byte state, then per symbol looks up, updates
// the state and renormalizes from the reversed byte stream.
// Optional final-state check enabled with `define RANS_DEC_STATE_CHECK_EN.
module rans_dec #(
    parameter int RESOLUTION   = rans_pkg::RESOLUTION,
    parameter int SYMBOL_WIDTH = rans_pkg::SYMBOL_WIDTH,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    freq_wr_i,
    input  logic                    slot_wr_i,
    input  logic [RESOLUTION-1:0]   freq_i,
    input  logic [RESOLUTION-1:0]   cum_freq_i,
    input  logic [RESOLUTION-1:0]   slot_i,
    input  logic [SYMBOL_WIDTH-1:0] symb_i,
    input  logic                    start_i,
    input  logic [COUNT_WIDTH-1:0]  num_i,
    rans_dec_if.slave               bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    import rans_pkg::*;

    localparam int                XW    = RESOLUTION + SYMBOL_WIDTH;
    localparam logic [XW-1:0]     X_MIN = XW'(1) << RESOLUTION;

    state_e                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]              ld_q, ld_d;
    logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
    logic                    done_q, done_d;
    logic                    in_rdy;

    logic [SYMBOL_WIDTH-1:0] t_symb;
    logic [RESOLUTION-1:0]   t_freq, t_cum;
    logic [RESOLUTION-1:0]   slot;
    logic [XW-1:0]           x_shift, x_calc;
    logic                    tbl_en;

    assign slot    = x_q[RESOLUTION-1:0];
    assign x_shift = {x_q[RESOLUTION-1:0], bus.in_byte};
    assign x_calc  = XW'(t_freq) * XW'(x_q >> RESOLUTION) + XW'(slot) - XW'(t_cum);
    assign tbl_en  = (state_q == IDLE);

    rans_dec_tables #(
        .RESOLUTION   (RESOLUTION),
        .SYMBOL_WIDTH (SYMBOL_WIDTH)
    ) u_tables (
        .clk_i      (clk_i),
        .freq_wr_i  (freq_wr_i & tbl_en),
        .slot_wr_i  (slot_wr_i & tbl_en),
        .freq_i     (freq_i),
        .cum_freq_i (cum_freq_i),
        .slot_i     (slot_i),
        .symb_i     (symb_i),
        .rd_slot_i  (slot),
        .rd_symb_o  (t_symb),
        .rd_freq_o  (t_freq),
        .rd_cum_o   (t_cum)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= X_MIN;
            cnt_q   <= '0;
            ld_q    <= '0;
            sym_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            sym_q   <= sym_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        sym_d   = sym_q;
        done_d  = 1'b0;
        in_rdy  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = num_i;
                        ld_d    = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    x_d  = x_shift;
                    ld_d = ld_q + 2'd1;
                    if (ld_q == 2'd2) state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = CALC;
            CALC: begin
                x_d     = x_calc;
                sym_d   = t_symb;
                state_d = RENORM;
            end
            RENORM: begin
                // The byte that lifts x into range moves straight on to OUT.
                if (x_q < X_MIN) begin
                    in_rdy = 1'b1;
                    if (bus.in_valid) begin
                        x_d = x_shift;
                        if (x_shift >= X_MIN) state_d = OUT;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.sym_ready) begin
                    cnt_d = cnt_q - COUNT_WIDTH'(1);
                    if (cnt_q == COUNT_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = LOOKUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RANS_DEC_STATE_CHECK_EN
    logic err_q;

    // A correctly framed stream returns the state to its initial value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (done_d) begin
            err_q <= (x_q != X_MIN);
        end else if (start_i && state_q == IDLE) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.sym_valid = (state_q == OUT);
    assign bus.sym       = sym_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_rans_dec.sv
// Directed bench for rans_dec: hand-computed decode vectors, stall, num=0,
// ignored start, mid-decode reset and the optional final-state check.
`timescale 1ns/1ps
module tb_rans_dec;

    import rans_pkg::*;

    typedef logic [7:0] bytes_t [6];

`ifdef RANS_DEC_STATE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        freq_wr_i = 1'b0, slot_wr_i = 1'b0;
    logic [9:0]  freq_i = '0, cum_freq_i = '0, slot_i = '0;
    logic [7:0]  symb_i = '0;
    logic        start_i = 1'b0;
    logic [15:0] num_i = '0;
    logic        busy_o, done_o, err_o;

    rans_dec_if bi ();

    rans_dec dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .freq_wr_i  (freq_wr_i),
        .slot_wr_i  (slot_wr_i),
        .freq_i     (freq_i),
        .cum_freq_i (cum_freq_i),
        .slot_i     (slot_i),
        .symb_i     (symb_i),
        .start_i    (start_i),
        .num_i      (num_i),
        .bus        (bi),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_err = 0;
    int n_bytes = 0, n_done = 0, n_sym = 0, n_rdy = 0;
    logic [7:0] last_sym = '0;

    always @(negedge clk_i) begin
        if (bi.in_valid && bi.in_ready) n_bytes++;
        if (bi.in_ready) n_rdy++;
        if (done_o) n_done++;
        if (bi.sym_valid && bi.sym_ready) begin
            n_sym++;
            last_sym = bi.sym;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wr_slot(input int s, input logic [7:0] sy);
        slot_wr_i = 1'b1; slot_i = 10'(s); symb_i = sy;
        tick(1);
        slot_wr_i = 1'b0;
    endtask

    task automatic wr_freq(input logic [7:0] sy, input int f, input int c);
        freq_wr_i = 1'b1; symb_i = sy; freq_i = 10'(f); cum_freq_i = 10'(c);
        tick(1);
        freq_wr_i = 1'b0;
    endtask

    task automatic start(input logic [15:0] n);
        start_i = 1'b1; num_i = n;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bi.in_valid = 1'b1; bi.in_byte = b;
        forever begin
            @(negedge clk_i);
            if (bi.in_ready) break;
            t++;
            if (t > 100) begin
                chk("byte_timeout", 0, 1);
                break;
            end
        end
        tick(1);
        bi.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done_o !== 1'b1 && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        chk({tag, "_done"}, 32'(done_o), 1);
        tick(1);
    endtask

    task automatic run(input string tag, input logic [15:0] n, input bytes_t b, input int nb,
                       input logic [7:0] es, input logic [17:0] ex, input int ns);
        int b0 = n_bytes, d0 = n_done, s0 = n_sym;
        start(n);
        for (int i = 0; i < nb; i++) send_byte(b[i]);
        wait_done(tag);
        tick(2);
        chk({tag, "_sym"},   32'(last_sym), 32'(es));
        chk({tag, "_x"},     32'(dut.x_q), 32'(ex));
        chk({tag, "_bytes"}, 32'(n_bytes - b0), 32'(nb));
        chk({tag, "_nsym"},  32'(n_sym - s0), 32'(ns));
        chk({tag, "_ndone"}, 32'(n_done - d0), 1);
        chk({tag, "_err"},   32'(err_o), 32'(CHK && ex != 18'd1024));
        chk({tag, "_busy"},  32'(busy_o), 0);
    endtask

    initial begin
        int b0, d0, s0, r0, t;
        bi.in_valid = 1'b0; bi.in_byte = '0; bi.sym_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_done",  32'(done_o), 0);
        chk("rst_err",   32'(err_o), 0);
        chk("rst_inrdy", 32'(bi.in_ready), 0);
        chk("rst_symv",  32'(bi.sym_valid), 0);
        chk("rst_sym",   32'(bi.sym), 0);
        chk("rst_x",     32'(dut.x_q), 1024);
        rst_i = 1'b0;
        tick(1);

        for (int s = 0; s < 1024; s++) wr_slot(s, (s < 512) ? 8'h41 : 8'h42);
        wr_freq(8'h41, 512, 0);
        wr_freq(8'h42, 512, 512);

        run("one", 16'd1, '{8'h00, 8'h04, 8'h00, 8'h12, 8'h00, 8'h00}, 4, 8'h41, 18'd131090, 1);
        run("ok",  16'd1, '{8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 8'h41, 18'd1024, 1);
        run("bad", 16'd1, '{8'h00, 8'h08, 8'h01, 8'h00, 8'h00, 8'h00}, 3, 8'h41, 18'd1025, 1);
        run("two", 16'd2, '{8'h00, 8'h08, 8'h00, 8'h12, 8'h00, 8'h00}, 4, 8'h41, 18'd131090, 2);

        // second symbol, with a start pulse while busy that must be ignored
        b0 = n_bytes; d0 = n_done; s0 = n_sym;
        start(16'd1);
        send_byte(8'h00);
        start(16'd5);
        send_byte(8'h06);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done("sb");
        tick(4);
        chk("sb_sym",   32'(last_sym), 32'h42);
        chk("sb_x",     32'(dut.x_q), 131072);
        chk("sb_bytes", 32'(n_bytes - b0), 4);
        chk("sb_nsym",  32'(n_sym - s0), 1);
        chk("sb_ndone", 32'(n_done - d0), 1);
        chk("sb_busy",  32'(busy_o), 0);

        // output stall
        bi.sym_ready = 1'b0;
        start(16'd1);
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h12);
        t = 0;
        while (bi.sym_valid !== 1'b1 && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("hold_symv",  32'(bi.sym_valid), 1);
            chk("hold_sym",   32'(bi.sym), 32'h41);
            chk("hold_inrdy", 32'(bi.in_ready), 0);
        end
        @(posedge clk_i);
        #1;
        bi.sym_ready = 1'b1;
        wait_done("hold");

        // num = 0
        r0 = n_rdy; d0 = n_done;
        start(16'd0);
        chk("num0_done", 32'(done_o), 1);
        chk("num0_busy", 32'(busy_o), 0);
        tick(1);
        chk("num0_done_off", 32'(done_o), 0);
        tick(3);
        chk("num0_inrdy",  32'(n_rdy - r0), 0);
        chk("num0_ndone",  32'(n_done - d0), 1);

        // reset while renormalizing
        wr_slot(0, 8'h07);
        wr_freq(8'h07, 1, 0);
        start(16'd1);
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
        t = 0;
        while (!(dut.state_q == RENORM && bi.in_ready) && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("rr_renorm", 32'(bi.in_ready), 1);
        d0 = n_done;
        rst_i = 1'b1;
        #1;
        chk("rr_busy",  32'(busy_o), 0);
        chk("rr_inrdy", 32'(bi.in_ready), 0);
        chk("rr_x",     32'(dut.x_q), 1024);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tick(5);
        chk("rr_ndone", 32'(n_done - d0), 0);

        // tables survive reset; two renorm bytes
        run("ren2", 16'd1, '{8'h00, 8'h04, 8'h00, 8'hAB, 8'hCD, 8'h00}, 5, 8'h07, 18'h1ABCD, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
